// File: rtl/rom_rd_arbiter.sv
// Three-client arbiter for the single SDRAM ROM read port, with toggle handshakes
// on every side and an optional one-entry last-read buffer.
module rom_rd_arbiter #(
    parameter bit RR    = 1'b1,
    parameter bit REUSE = 1'b1
) (
    input  logic        clk,
    input  logic        init_n,
    input  logic        m68k_req,
    output logic        m68k_ack,
    input  logic [23:1] m68k_a,
    output logic [15:0] m68k_q,
    input  logic        z80_req,
    output logic        z80_ack,
    input  logic [23:1] z80_a,
    output logic [15:0] z80_q,
    input  logic        dma_req,
    output logic        dma_ack,
    input  logic [23:1] dma_a,
    output logic [15:0] dma_q,
    input  logic        inval,
    output logic        romrd_req,
    input  logic        romrd_ack,
    output logic [23:1] romrd_a,
    input  logic [15:0] romrd_q
);

    typedef enum logic [1:0] {S_IDLE, S_HIT, S_WAIT} state_t;

    localparam logic [1:0] ID_M68K = 2'd0;
    localparam logic [1:0] ID_Z80  = 2'd1;
    localparam logic [1:0] ID_DMA  = 2'd2;

    state_t      state_q;
    logic [1:0]  sel_q;
    logic [1:0]  last_q;
    logic [2:0]  ack_q;
    logic [15:0] cq_q [3];
    logic        romrd_req_q;
    logic [23:1] romrd_a_q;
    logic        buf_valid_q;
    logic [23:1] buf_addr_q;
    logic [15:0] buf_data_q;
    logic        dirty_q;

    logic [2:0]  req_vec;
    logic [2:0]  pend;
    logic [1:0]  grant_id;
    logic [1:0]  cand;
    logic        found;
    logic [23:1] grant_addr;
    logic        grant_hit;

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == ID_DMA) ? ID_M68K : id + 2'd1;
    endfunction

    assign req_vec = {dma_req, z80_req, m68k_req};
    assign pend    = req_vec ^ ack_q;

    // Round-robin starts one past the last grant; fixed priority always starts at m68k.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        grant_id = ID_M68K;
        found    = 1'b0;
        cand     = RR ? next_id(last_q) : ID_M68K;
        for (int k = 0; k < 3; k++) begin
            if (!found && pend[cand]) begin
                grant_id = cand;
                found    = 1'b1;
            end
            cand = next_id(cand);
        end
    end

    always_comb begin
        case (grant_id)
            ID_M68K: grant_addr = m68k_a;
            ID_Z80:  grant_addr = z80_a;
            default: grant_addr = dma_a;
        endcase
        grant_hit = REUSE && buf_valid_q && !inval && (grant_addr == buf_addr_q);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            state_q     <= S_IDLE;
            sel_q       <= ID_M68K;
            last_q      <= ID_DMA;
            ack_q       <= '0;
            // NOTE: the client data registers are visible outputs, so they are reset too.
            for (int i = 0; i < 3; i++) cq_q[i] <= '0;
            romrd_req_q <= 1'b0;
            romrd_a_q   <= '0;
            buf_valid_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_data_q  <= '0;
            dirty_q     <= 1'b0;
        end else begin
            if (inval) buf_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        sel_q  <= grant_id;
                        last_q <= grant_id;
                        if (grant_hit) begin
                            state_q <= S_HIT;
                        end else begin
                            romrd_a_q   <= grant_addr;
                            romrd_req_q <= ~romrd_req_q;
                            dirty_q     <= 1'b0;
                            state_q     <= S_WAIT;
                        end
                    end
                end
                S_HIT: begin
                    cq_q[sel_q]  <= buf_data_q;
                    ack_q[sel_q] <= req_vec[sel_q];
                    state_q      <= S_IDLE;
                end
                S_WAIT: begin
                    if (romrd_ack == romrd_req_q) begin
                        cq_q[sel_q]  <= romrd_q;
                        ack_q[sel_q] <= req_vec[sel_q];
                        buf_addr_q   <= romrd_a_q;
                        buf_data_q   <= romrd_q;
                        // Any invalidate seen while the read was in flight makes this data stale.
                        buf_valid_q  <= !(inval || dirty_q);
                        state_q      <= S_IDLE;
                    end else if (inval) begin
                        dirty_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign m68k_ack  = ack_q[0];
    assign z80_ack   = ack_q[1];
    assign dma_ack   = ack_q[2];
    assign m68k_q    = cq_q[0];
    assign z80_q     = cq_q[1];
    assign dma_q     = cq_q[2];
    assign romrd_req = romrd_req_q;
    assign romrd_a   = romrd_a_q;

endmodule
